// File: rtl/sdram_init_controller.sv
`default_nettype none
// ============================================================================
// Module  : sdram_init_controller
// Brief   : SDRAM power-up sequencer issuing precharge-all, refreshes and mode
//           config requests. Optional ack timeout via SDRAM_INIT_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module sdram_init_controller #(
   parameter int POWERUP_CYCLES = 20000,
   parameter int REFRESH_TIMES  = 8,
   parameter int GAP_CYCLES     = 8,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sdram_inside_order_ack,
   output logic sdram_init_precharge_req,
   output logic sdram_init_refresh_req,
   output logic sdram_init_config_req,
   output logic sdram_init_done,
   output logic sdram_init_error
);

   localparam int RC_W = ($clog2(REFRESH_TIMES + 1) > 4) ? $clog2(REFRESH_TIMES + 1) : 4;

   localparam logic [CNT_WIDTH-1:0] c_POWERUP_LAST  = CNT_WIDTH'(POWERUP_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] c_GAP_LAST      = CNT_WIDTH'(GAP_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] c_TIMEOUT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] c_CNT_MAX       = '1;
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE       = CNT_WIDTH'(1);
   localparam logic [RC_W-1:0]      c_REFRESH_TIMES = RC_W'(REFRESH_TIMES);
   localparam logic [RC_W-1:0]      c_REF_ONE       = RC_W'(1);

   typedef enum logic [3:0] {
      S_POWERUP   = 4'd0,
      S_PRECHARGE = 4'd1,
      S_GAP_P     = 4'd2,
      S_REFRESH   = 4'd3,
      S_GAP_R     = 4'd4,
      S_CONFIG    = 4'd5,
      S_GAP_C     = 4'd6,
      S_DONE      = 4'd7,
      S_ERROR     = 4'd8
   } state_t;

   state_t               r_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [RC_W-1:0]      r_ref_cnt;
   logic                 r_pre_req;
   logic                 r_ref_req;
   logic                 r_cfg_req;
   logic                 r_done;
   logic                 r_error;

   logic [CNT_WIDTH-1:0] w_cnt_inc;
   logic                 w_ack;
   logic                 w_gap_end;
   logic                 w_timeout;

   // Saturate so a long wait never wraps the counter back to zero.
   assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : (r_cnt + c_CNT_ONE);
   assign w_ack     = sdram_inside_order_ack;
   assign w_gap_end = (r_cnt == c_GAP_LAST);

`ifdef SDRAM_INIT_TIMEOUT_EN
   assign w_timeout = (r_cnt == c_TIMEOUT_LAST);
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^c_TIMEOUT_LAST;
   assign w_timeout        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_POWERUP;
         r_cnt     <= '0;
         r_ref_cnt <= '0;
         r_pre_req <= 1'b0;
         r_ref_req <= 1'b0;
         r_cfg_req <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         case (r_state)
            S_POWERUP: begin
               if (r_cnt == c_POWERUP_LAST) begin
                  r_state   <= S_PRECHARGE;
                  r_cnt     <= '0;
                  r_pre_req <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_PRECHARGE: begin
               if (w_ack) begin
                  r_state   <= S_GAP_P;
                  r_cnt     <= '0;
                  r_pre_req <= 1'b0;
               end else if (w_timeout) begin
                  r_state   <= S_ERROR;
                  r_cnt     <= '0;
                  r_pre_req <= 1'b0;
                  r_error   <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_GAP_P: begin
               if (w_gap_end) begin
                  r_state   <= S_REFRESH;
                  r_cnt     <= '0;
                  r_ref_req <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_REFRESH: begin
               if (w_ack) begin
                  r_state   <= S_GAP_R;
                  r_cnt     <= '0;
                  r_ref_req <= 1'b0;
                  r_ref_cnt <= r_ref_cnt + c_REF_ONE;
               end else if (w_timeout) begin
                  r_state   <= S_ERROR;
                  r_cnt     <= '0;
                  r_ref_req <= 1'b0;
                  r_error   <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_GAP_R: begin
               if (w_gap_end) begin
                  r_cnt <= '0;
                  if (r_ref_cnt < c_REFRESH_TIMES) begin
                     r_state   <= S_REFRESH;
                     r_ref_req <= 1'b1;
                  end else begin
                     r_state   <= S_CONFIG;
                     r_cfg_req <= 1'b1;
                  end
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_CONFIG: begin
               if (w_ack) begin
                  r_state   <= S_GAP_C;
                  r_cnt     <= '0;
                  r_cfg_req <= 1'b0;
               end else if (w_timeout) begin
                  r_state   <= S_ERROR;
                  r_cnt     <= '0;
                  r_cfg_req <= 1'b0;
                  r_error   <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_GAP_C: begin
               if (w_gap_end) begin
                  r_state <= S_DONE;
                  r_cnt   <= '0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            S_DONE: begin
               r_done <= 1'b1;
            end
            S_ERROR: begin
               r_error <= 1'b1;
            end
            default: begin
               r_state   <= S_POWERUP;
               r_cnt     <= '0;
               r_pre_req <= 1'b0;
               r_ref_req <= 1'b0;
               r_cfg_req <= 1'b0;
            end
         endcase
      end
   end

   assign sdram_init_precharge_req = r_pre_req;
   assign sdram_init_refresh_req   = r_ref_req;
   assign sdram_init_config_req    = r_cfg_req;
   assign sdram_init_done          = r_done;
   assign sdram_init_error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdram_init_controller
// Brief   : Randomized bench; expected request timeline computed arithmetically.
// Revision: 1.0
// ============================================================================
module tb_sdram_init_controller;

   localparam int P    = 10;
   localparam int R    = 2;
   localparam int G    = 3;
   localparam int T    = 16;
   localparam int NREQ = R + 2;
   localparam int BUDGET = 200;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ack = 1'b0;
   logic w_pre, w_ref, w_cfg, w_done, w_err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int r_rel = 0;
   int ref_rises = 0;
   logic prev_ref = 1'b0;

   sdram_init_controller #(
      .POWERUP_CYCLES (P),
      .REFRESH_TIMES  (R),
      .GAP_CYCLES     (G),
      .CNT_WIDTH      (16),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .sdram_inside_order_ack   (ack),
      .sdram_init_precharge_req (w_pre),
      .sdram_init_refresh_req   (w_ref),
      .sdram_init_config_req    (w_cfg),
      .sdram_init_done          (w_done),
      .sdram_init_error         (w_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      checks++;
      if ((32'(w_pre) + 32'(w_ref) + 32'(w_cfg)) > 1) begin
         failures++;
         $display("FAIL onehot: reqs(pre,ref,cfg)=%b required at most one high", {w_pre, w_ref, w_cfg});
      end
`ifndef SDRAM_INIT_TIMEOUT_EN
      checks++;
      if (w_err !== 1'b0) begin
         failures++;
         $display("FAIL error_tied: error=%b required 0", w_err);
      end
`endif
      if (w_ref && !prev_ref) ref_rises++;
      prev_ref = w_ref;
   end

   function automatic int req_kind();
      if (w_pre === 1'b1) return 1;
      if (w_ref === 1'b1) return 2;
      if (w_cfg === 1'b1) return 3;
      return 0;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      ack   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      r_rel = cyc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({w_pre, w_ref, w_cfg, w_done, w_err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_state: outputs=%b required 00000", {w_pre, w_ref, w_cfg, w_done, w_err});
      end
   endtask

   // mode 0: ack 2 cycles after rise; 1: random delay; 2: ack held high; 3: random delay plus stray acks
   task automatic run_sequence(input int mode);
      int  d, n, t, exp_rise, exp_kind, ref_start;
      bit  ok;
      logic hold;
      hold = (mode == 2);
      do_reset();
      ref_start = ref_rises;
      exp_rise = P;
      for (int k = 0; k < NREQ; k++) begin
         exp_kind = (k == 0) ? 1 : ((k == NREQ - 1) ? 3 : 2);
         d = (mode == 0) ? 2 : ((mode == 2) ? 0 : int'($urandom_range(0, 4)));
         n = 0;
         while (req_kind() == 0 && n < BUDGET) begin
            ack = hold | ((mode == 3) && ($urandom_range(0, 2) == 0));
            @(negedge clk);
            n++;
         end
         checks++;
         if (n >= BUDGET) begin
            failures++;
            $display("FAIL req_wait_m%0d: req %0d never rose, required rise at cycle %0d", mode, k, exp_rise);
            return;
         end
         t = cyc - r_rel;
         checks++;
         if (req_kind() !== exp_kind) begin
            failures++;
            $display("FAIL req_kind_m%0d: req %0d kind=%0d required %0d", mode, k, req_kind(), exp_kind);
         end
         checks++;
         if (t !== exp_rise) begin
            failures++;
            $display("FAIL req_rise_m%0d: req %0d rose at %0d required %0d", mode, k, t, exp_rise);
         end
         ok = 1'b1;
         for (int j = 0; j < d; j++) begin
            ack = hold;
            @(negedge clk);
            if (req_kind() != exp_kind) ok = 1'b0;
         end
         ack = 1'b1;
         @(negedge clk);
         ack = hold;
         checks++;
         if (req_kind() != 0 || !ok) begin
            failures++;
            $display("FAIL req_len_m%0d: req %0d held=%0b kind_after=%0d required %0d cycles then 0",
                     mode, k, ok, req_kind(), d + 1);
         end
         exp_rise = exp_rise + d + 1 + G;
      end
      n = 0;
      while (w_done !== 1'b1 && n < BUDGET) begin
         ack = hold | ((mode == 3) && ($urandom_range(0, 2) == 0));
         @(negedge clk);
         n++;
      end
      t = cyc - r_rel;
      checks++;
      if (t !== exp_rise || w_done !== 1'b1) begin
         failures++;
         $display("FAIL done_time_m%0d: done=%b at %0d required 1 at %0d", mode, w_done, t, exp_rise);
      end
      ok = 1'b1;
      for (int j = 0; j < 8; j++) begin
         ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (w_done !== 1'b1 || req_kind() != 0 || w_err !== 1'b0) ok = 1'b0;
      end
      ack = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL done_sticky_m%0d: done/reqs changed after DONE, required done=1 reqs=0", mode);
      end
      checks++;
      if (ref_rises - ref_start !== R) begin
         failures++;
         $display("FAIL refresh_count_m%0d: got %0d refresh reqs required %0d", mode, ref_rises - ref_start, R);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (req_kind() == 0 && n < BUDGET) begin
            @(negedge clk);
            n++;
         end
         if (k < 2) begin
            @(negedge clk);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
         end
      end
      checks++;
      if (req_kind() !== 2) begin
         failures++;
         $display("FAIL mid_kind: req kind=%0d required 2 (second refresh)", req_kind());
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({w_pre, w_ref, w_cfg, w_done, w_err} !== 5'b0) begin
         failures++;
         $display("FAIL mid_reset_async: outputs=%b required 00000", {w_pre, w_ref, w_cfg, w_done, w_err});
      end
      @(negedge clk);
      checks++;
      if ({w_pre, w_ref, w_cfg, w_done, w_err} !== 5'b0) begin
         failures++;
         $display("FAIL mid_reset_next: outputs=%b required 00000", {w_pre, w_ref, w_cfg, w_done, w_err});
      end
      run_sequence(0);
   endtask

`ifdef SDRAM_INIT_TIMEOUT_EN
   task automatic test_timeout();
      int n, t;
      bit ok;
      do_reset();
      n = 0;
      while (req_kind() == 0 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      t = cyc - r_rel;
      checks++;
      if (t !== P || req_kind() !== 1) begin
         failures++;
         $display("FAIL to_rise: kind=%0d at %0d required 1 at %0d", req_kind(), t, P);
      end
      n = 0;
      while (req_kind() == 1 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== T) begin
         failures++;
         $display("FAIL to_len: precharge high %0d cycles required %0d", n, T);
      end
      checks++;
      if (w_err !== 1'b1 || w_done !== 1'b0 || req_kind() != 0) begin
         failures++;
         $display("FAIL to_error: err=%b done=%b kind=%0d required 1 0 0", w_err, w_done, req_kind());
      end
      ok = 1'b1;
      for (int j = 0; j < 20; j++) begin
         ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (w_err !== 1'b1 || w_done !== 1'b0 || req_kind() != 0) ok = 1'b0;
      end
      ack = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL to_sticky: error state left before reset, required err=1 done=0");
      end
      do_reset();
      @(negedge clk);
      checks++;
      if (w_err !== 1'b0) begin
         failures++;
         $display("FAIL to_clear: err=%b after reset required 0", w_err);
      end
   endtask
`else
   task automatic test_no_timeout();
      int n;
      bit ok;
      do_reset();
      n = 0;
      while (req_kind() == 0 && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      ok = (req_kind() == 1);
      for (int j = 0; j < 3 * T; j++) begin
         @(negedge clk);
         if (req_kind() != 1 || w_err !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL no_timeout: kind=%0d err=%b required precharge held, err 0", req_kind(), w_err);
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checks++;
      if (req_kind() != 0) begin
         failures++;
         $display("FAIL late_ack: kind=%0d after ack required 0", req_kind());
      end
   endtask
`endif

   initial begin
      test_reset();
      run_sequence(0);
      run_sequence(2);
      for (int i = 0; i < 3; i++) run_sequence(1);
      for (int i = 0; i < 2; i++) run_sequence(3);
      test_reset_mid();
`ifdef SDRAM_INIT_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
